// File: rtl/seg7_digit_sequencer.sv
// seg7_digit_sequencer: prescaled digit counter with pin load,
// hex 7-segment decode and a wrap-toggled decimal point.
module seg7_digit_sequencer #(
   parameter int PRESCALE   = 1000,
   parameter int MAX_DIGIT  = 15,
   parameter bit COUNT_DOWN = 1'b0
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int            PW      = $clog2(PRESCALE);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
   localparam logic [3:0]    MAX_D   = 4'(MAX_DIGIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_LOAD
   } state_t;

   logic          w_clk;
   logic          w_rst;
   logic [5:0]    r_sync1;
   logic [5:0]    r_sync2;
   logic          r_load_d;
   state_t        r_state;
   state_t        w_state_nx;
   logic [PW-1:0] r_ps;
   logic [PW-1:0] w_ps_nx;
   logic [3:0]    r_digit;
   logic [3:0]    w_digit_nx;
   logic          r_dp;
   logic          w_dp_nx;
   logic [6:0]    r_seg;
   logic [6:0]    w_seg;
   logic          w_run;
   logic          w_load_rise;
   logic          w_tick;
   logic [3:0]    w_data;

   assign w_clk       = io_in[0];
   assign w_rst       = io_in[1];
   assign w_run       = r_sync2[0];
   assign w_data      = r_sync2[5:2];
   assign w_load_rise = r_sync2[1] & ~r_load_d;
   // A load edge swallows a coincident tick.
   assign w_tick      = (r_state == S_RUN) && !w_load_rise
                        && (r_ps == PS_LAST);
   assign io_out      = {r_dp, r_seg};

   // Two-flop synchronisers for run/load/data plus load edge history
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_load_d <= 1'b0;
      end else begin
         r_sync1  <= io_in[7:2];
         r_sync2  <= r_sync1;
         r_load_d <= r_sync2[1];
      end
   end

   // Next state, prescaler, digit step / load and wrap toggle
   always_comb begin
      w_state_nx = r_state;
      w_ps_nx    = r_ps;
      w_digit_nx = r_digit;
      w_dp_nx    = r_dp;
      unique case (r_state)
         S_IDLE, S_RUN: begin
            if (w_load_rise) begin
               w_state_nx = S_LOAD;
            end else if (w_run) begin
               w_state_nx = S_RUN;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_LOAD: begin
            w_state_nx = w_run ? S_RUN : S_IDLE;
            w_ps_nx    = '0;
            w_digit_nx = (w_data > MAX_D) ? MAX_D : w_data;
         end
         default: w_state_nx = S_IDLE;
      endcase
      if ((r_state == S_RUN) && !w_load_rise) begin
         w_ps_nx = w_tick ? '0 : r_ps + 1'b1;
      end
      if (w_tick) begin
         if (COUNT_DOWN) begin
            if (r_digit == 4'd0) begin
               w_digit_nx = MAX_D;
               w_dp_nx    = ~r_dp;
            end else begin
               w_digit_nx = r_digit - 4'd1;
            end
         end else begin
            if (r_digit == MAX_D) begin
               w_digit_nx = 4'd0;
               w_dp_nx    = ~r_dp;
            end else begin
               w_digit_nx = r_digit + 4'd1;
            end
         end
      end
   end

   // Hex digit to {g,f,e,d,c,b,a}
   always_comb begin
      w_seg = 7'h71;
      case (r_digit)
         4'h0:    w_seg = 7'h3F;
         4'h1:    w_seg = 7'h06;
         4'h2:    w_seg = 7'h5B;
         4'h3:    w_seg = 7'h4F;
         4'h4:    w_seg = 7'h66;
         4'h5:    w_seg = 7'h6D;
         4'h6:    w_seg = 7'h7D;
         4'h7:    w_seg = 7'h07;
         4'h8:    w_seg = 7'h7F;
         4'h9:    w_seg = 7'h6F;
         4'hA:    w_seg = 7'h77;
         4'hB:    w_seg = 7'h7C;
         4'hC:    w_seg = 7'h39;
         4'hD:    w_seg = 7'h5E;
         4'hE:    w_seg = 7'h79;
         default: w_seg = 7'h71;
      endcase
   end

   // State, prescaler, digit, dp and registered segment outputs
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         r_state <= S_IDLE;
         r_ps    <= '0;
         r_digit <= 4'd0;
         r_dp    <= 1'b0;
         r_seg   <= 7'h3F;
      end else begin
         r_state <= w_state_nx;
         r_ps    <= w_ps_nx;
         r_digit <= w_digit_nx;
         r_dp    <= w_dp_nx;
         r_seg   <= w_seg;
      end
   end

endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// tb_seg7_digit_sequencer: three sequencer variants (hex up, decimal
// up, hex down) against a cycle model plus directed timing sequences.
module tb_seg7_digit_sequencer;

   localparam int PS = 4;
   localparam logic [6:0] SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   localparam int MAXV [3] = '{15, 9, 15};
   localparam bit DNV  [3] = '{1'b0, 1'b0, 1'b1};

   typedef struct {
      logic [3:0] data;
      logic [6:0] hex;
      logic [6:0] dec;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       load = 1'b0;
   logic [3:0] data = 4'h0;
   bit         clk_en = 1'b0;
   bit         chk_en = 1'b0;
   logic [7:0] w_io_in;
   logic [7:0] out_hex;
   logic [7:0] out_dec;
   logic [7:0] out_dn;
   logic [7:0] g_got;
   int         checks = 0;
   int         failures = 0;

   // reference model state (one slot per DUT variant)
   int         m_digit [3];
   int         m_count [3];
   bit         m_dp    [3];
   bit         m_run   [3];
   bit         m_ldg   [3];
   logic [6:0] m_seg   [3];
   logic [5:0] m_d0;
   logic [5:0] m_d1;
   bit         m_prev;
   bit         m_rise;
   bit         m_nl;
   int         m_data;

   assign w_io_in = {data, load, run, rst, clk};

   seg7_digit_sequencer #(.PRESCALE(PS), .MAX_DIGIT(15), .COUNT_DOWN(1'b0))
      u_hex (.io_in(w_io_in), .io_out(out_hex));
   seg7_digit_sequencer #(.PRESCALE(PS), .MAX_DIGIT(9), .COUNT_DOWN(1'b0))
      u_dec (.io_in(w_io_in), .io_out(out_dec));
   seg7_digit_sequencer #(.PRESCALE(PS), .MAX_DIGIT(15), .COUNT_DOWN(1'b1))
      u_dn (.io_in(w_io_in), .io_out(out_dn));

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // Model: pins seen two clocks late; a seen rising load edge
   // suppresses counting, next cycle loads; every PS running cycles step.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_digit[i] = 0;
            m_count[i] = 0;
            m_dp[i]    = 1'b0;
            m_run[i]   = 1'b0;
            m_ldg[i]   = 1'b0;
            m_seg[i]   = 7'h3F;
         end
         m_d0   = '0;
         m_d1   = '0;
         m_prev = 1'b0;
      end else begin
         m_rise = m_d1[1] && !m_prev;
         m_data = int'(m_d1[5:2]);
         for (int i = 0; i < 3; i++) begin
            m_seg[i] = SEG[m_digit[i]];
            if (m_ldg[i]) begin
               m_digit[i] = (m_data > MAXV[i]) ? MAXV[i] : m_data;
               m_count[i] = 0;
            end else if (m_run[i] && !m_rise) begin
               m_count[i]++;
               if (m_count[i] == PS) begin
                  m_count[i] = 0;
                  if (DNV[i]) begin
                     if (m_digit[i] == 0) m_dp[i] = !m_dp[i];
                     m_digit[i] = (m_digit[i] + MAXV[i]) % (MAXV[i] + 1);
                  end else begin
                     m_digit[i] = (m_digit[i] + 1) % (MAXV[i] + 1);
                     if (m_digit[i] == 0) m_dp[i] = !m_dp[i];
                  end
               end
            end
            m_nl     = m_rise && !m_ldg[i];
            m_run[i] = !m_nl && m_d1[0];
            m_ldg[i] = m_nl;
         end
         m_prev = m_d1[1];
         m_d1   = m_d0;
         m_d0   = {data, load, run};
      end
   end

   // Continuous comparison of all three variants against the model
   initial forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
         for (int i = 0; i < 3; i++) begin
            case (i)
               0:       g_got = out_hex;
               1:       g_got = out_dec;
               default: g_got = out_dn;
            endcase
            checks++;
            if (g_got !== {m_dp[i], m_seg[i]}) begin
               failures++;
               $display("FAIL model inst=%0d t=%0t got=%h exp=%h",
                        i, $time, g_got, {m_dp[i], m_seg[i]});
            end
         end
      end
   end

   initial begin
      vec_t       tv [16];
      int         n;
      int         r;
      logic [7:0] s0;
      logic [7:0] s1;
      logic       d0;

      tv = '{
         '{4'h0, 7'h3F, 7'h3F}, '{4'h1, 7'h06, 7'h06},
         '{4'h2, 7'h5B, 7'h5B}, '{4'h3, 7'h4F, 7'h4F},
         '{4'h4, 7'h66, 7'h66}, '{4'h5, 7'h6D, 7'h6D},
         '{4'h6, 7'h7D, 7'h7D}, '{4'h7, 7'h07, 7'h07},
         '{4'h8, 7'h7F, 7'h7F}, '{4'h9, 7'h6F, 7'h6F},
         '{4'hA, 7'h77, 7'h6F}, '{4'hB, 7'h7C, 7'h6F},
         '{4'hC, 7'h39, 7'h6F}, '{4'hD, 7'h5E, 7'h6F},
         '{4'hE, 7'h79, 7'h6F}, '{4'hF, 7'h71, 7'h6F}
      };

      // 1. reset with clock stopped
      #3 rst = 1'b1;
      #1;
      chk("rst_hex", out_hex, 8'h3F);
      chk("rst_dec", out_dec, 8'h3F);
      chk("rst_dn", out_dn, 8'h3F);
      #20;
      chk("rst_hold", out_hex, 8'h3F);
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_hex", out_hex, 8'h3F);
      chk("idle_dn", out_dn, 8'h3F);

      // 2. hex up-count through the F->0 wrap
      run = 1'b1;
      n   = 0;
      while (out_hex[7] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk_int("wrap_hex_timeout", n, 67);
      end else begin
         chk_int("wrap_hex_cycles", n, 67);
         chk("wrap_hex_pre", out_hex, 8'hF1);
         @(negedge clk);
         chk("wrap_hex_post", out_hex, 8'hBF);
      end
      run = 1'b0;
      repeat (4) @(negedge clk);

      // 3a. segment table and load saturation
      for (int v = 0; v < 16; v++) begin
         data = tv[v].data;
         load = 1'b1;
         repeat (6) @(negedge clk);
         chk("tbl_hex", {1'b0, out_hex[6:0]}, {1'b0, tv[v].hex});
         chk("tbl_dec", {1'b0, out_dec[6:0]}, {1'b0, tv[v].dec});
         load = 1'b0;
         repeat (3) @(negedge clk);
      end

      // 3b. decimal 7,8,9,0
      data = 4'h7;
      load = 1'b1;
      repeat (6) @(negedge clk);
      load = 1'b0;
      chk("dec_load7", {1'b0, out_dec[6:0]}, 8'h07);
      d0  = out_dec[7];
      run = 1'b1;
      n   = 0;
      while (out_dec[7] === d0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk_int("dec_wrap_cycles", n, 15);
      chk("dec_wrap_pre", out_dec, {~d0, 7'h6F});
      @(negedge clk);
      chk("dec_wrap_post", out_dec, {~d0, 7'h3F});

      // 4. load edge coincides with the tick
      n = 0;
      while (!(m_run[0] && !m_ldg[0] && m_count[0] == 1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_int("lbt_align", n < 20 ? 1 : 0, 1);
      data = 4'h5;
      load = 1'b1;
      repeat (3) @(negedge clk);
      s0 = out_hex;
      @(negedge clk);
      chk("lbt_no_step", out_hex, s0);
      n = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (out_hex === {s0[7], 7'h6D}) n++;
      end
      chk_int("lbt_hold5", n, 4);
      @(negedge clk);
      chk("lbt_next", out_hex, {s0[7], 7'h7D});
      load = 1'b0;

      // 5. pause two cycles into a period, then resume
      n = 0;
      while (!(m_run[0] && m_count[0] == 3) && n < 20) begin
         @(negedge clk);
         n++;
      end
      run = 1'b0;
      repeat (3) @(negedge clk);
      s1 = out_hex;
      repeat (10) @(negedge clk);
      chk("pause_hold", out_hex, s1);
      run = 1'b1;
      n   = 0;
      while (out_hex === s1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_int("resume_cycles", n, 6);

      // 6. reset mid-period, then down-count wrap 0->F
      n = 0;
      while (!(m_run[0] && m_count[0] == 1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      #2 rst = 1'b1;
      #1;
      chk("midrst_hex", out_hex, 8'h3F);
      chk("midrst_dec", out_dec, 8'h3F);
      chk("midrst_dn", out_dn, 8'h3F);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n   = 0;
      while (out_dn[7] !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk_int("down_wrap_cycles", n, 7);
      chk("down_wrap_pre", out_dn, 8'hBF);
      @(negedge clk);
      chk("down_wrap_post", out_dn, 8'hF1);

      // 7. random pin activity against the model
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         r = int'($urandom % 100);
         if (r < 10) run = ~run;
         if (r >= 10 && r < 22) load = ~load;
         if (r >= 50 && r < 60) data = 4'($urandom);
         if (r == 99) begin
            #2 rst = 1'b1;
            #1;
            chk("rnd_rst", out_dec, 8'h3F);
            @(negedge clk);
            rst = 1'b0;
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
